// File: rtl/give_sel_pipe.sv
// Registered A/B/max/min operand selector with valid/ready handshake and a
// saturating count of A-sourced results. Define GIVE_SEL_SIGNED_EN for signed max/min.
module give_sel_pipe #(
  parameter int WIDTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       mode,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_from_a,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] a_sel_count
);

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_from_a_q, out_from_a_d;
  logic             out_valid_q, out_valid_d;
  logic [CNT_W-1:0] a_sel_count_q, a_sel_count_d;

  logic             a_ge_b_s, a_le_b_s;
  logic [WIDTH-1:0] result_s;
  logic             from_a_s;
  logic             accept_s;

  assign in_ready = !out_valid_q || out_ready;
  assign accept_s = in_valid && in_ready;

  // Operand comparison, signed or unsigned by build
  always_comb begin
`ifdef GIVE_SEL_SIGNED_EN
    a_ge_b_s = $signed(a) >= $signed(b);
    a_le_b_s = $signed(a) <= $signed(b);
`else
    a_ge_b_s = a >= b;
    a_le_b_s = a <= b;
`endif
  end

  // Result selection; ties go to A
  always_comb begin
    result_s = a;
    from_a_s = 1'b1;
    case (mode)
      2'b00: begin
        result_s = a;
        from_a_s = 1'b1;
      end
      2'b01: begin
        result_s = b;
        from_a_s = 1'b0;
      end
      2'b10: begin
        if (a_ge_b_s) begin
          result_s = a;
          from_a_s = 1'b1;
        end else begin
          result_s = b;
          from_a_s = 1'b0;
        end
      end
      2'b11: begin
        if (a_le_b_s) begin
          result_s = a;
          from_a_s = 1'b1;
        end else begin
          result_s = b;
          from_a_s = 1'b0;
        end
      end
      default: begin
        result_s = a;
        from_a_s = 1'b1;
      end
    endcase
  end

  // Output register next state: load on accept, empty on drain
  always_comb begin
    out_data_d   = out_data_q;
    out_from_a_d = out_from_a_q;
    out_valid_d  = out_valid_q;
    if (accept_s) begin
      out_data_d   = result_s;
      out_from_a_d = from_a_s;
      out_valid_d  = 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d  = 1'b0;
    end else begin
      out_valid_d  = out_valid_q;
    end
  end

  // Saturating A-select counter; clear beats increment
  always_comb begin
    a_sel_count_d = a_sel_count_q;
    if (cnt_clr) begin
      a_sel_count_d = {CNT_W{1'b0}};
    end else if (accept_s && from_a_s && (a_sel_count_q != {CNT_W{1'b1}})) begin
      a_sel_count_d = a_sel_count_q + CNT_W'(1);
    end else begin
      a_sel_count_d = a_sel_count_q;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q    <= {WIDTH{1'b0}};
      out_from_a_q  <= 1'b0;
      out_valid_q   <= 1'b0;
      a_sel_count_q <= {CNT_W{1'b0}};
    end else begin
      out_data_q    <= out_data_d;
      out_from_a_q  <= out_from_a_d;
      out_valid_q   <= out_valid_d;
      a_sel_count_q <= a_sel_count_d;
    end
  end

  assign out_data    = out_data_q;
  assign out_from_a  = out_from_a_q;
  assign out_valid   = out_valid_q;
  assign a_sel_count = a_sel_count_q;

endmodule

// File: tb/tb_give_sel_pipe.sv
// Scoreboard bench for give_sel_pipe (WIDTH=2, CNT_W=2); honours GIVE_SEL_SIGNED_EN.
module tb_give_sel_pipe;

  localparam int W = 2;
  localparam int CW = 2;

  logic          clk;
  logic          rst_n;
  logic [W-1:0]  a, b;
  logic [1:0]    mode;
  logic          in_valid, in_ready;
  logic [W-1:0]  out_data;
  logic          out_from_a, out_valid, out_ready, cnt_clr;
  logic [CW-1:0] a_sel_count;

  int            n_pass  = 0;
  int            n_total = 0;
  logic [W:0]    exp_q[$];
  logic [CW-1:0] cnt_exp;

  give_sel_pipe #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .mode(mode),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_from_a(out_from_a), .out_valid(out_valid),
    .out_ready(out_ready), .cnt_clr(cnt_clr), .a_sel_count(a_sel_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic logic [W:0] model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                       input logic [1:0] m);
    int ai, bi;
    ai = int'(av);
    bi = int'(bv);
`ifdef GIVE_SEL_SIGNED_EN
    if (av[W-1]) ai = ai - (1 << W);
    if (bv[W-1]) bi = bi - (1 << W);
`endif
    case (m)
      2'd0:    return {1'b1, av};
      2'd1:    return {1'b0, bv};
      2'd2:    return (ai >= bi) ? {1'b1, av} : {1'b0, bv};
      default: return (ai <= bi) ? {1'b1, av} : {1'b0, bv};
    endcase
  endfunction

  // Called just after a falling edge with inputs applied; checks, updates model, waits one cycle.
  task automatic step();
    logic       m_ready, acc;
    logic [W:0] r;
    #1;
    m_ready = (exp_q.size() == 0) || out_ready;
    check_val("in_ready", in_ready, m_ready);
    check_val("out_valid", out_valid, exp_q.size() != 0);
    check_val("a_sel_count", a_sel_count, cnt_exp);
    if (exp_q.size() != 0) begin
      check_val("out_data", out_data, exp_q[0][W-1:0]);
      check_val("out_from_a", out_from_a, exp_q[0][W]);
      if (out_ready) void'(exp_q.pop_front());
    end
    acc = in_valid && m_ready;
    r = model(a, b, mode);
    if (acc) exp_q.push_back(r);
    if (cnt_clr) cnt_exp = '0;
    else if (acc && r[W] && cnt_exp != {CW{1'b1}}) cnt_exp = cnt_exp + 2'd1;
    @(negedge clk);
  endtask

  task automatic drive(input logic [W-1:0] av, input logic [W-1:0] bv, input logic [1:0] m,
                       input logic v, input logic ordy, input logic clr);
    a = av; b = bv; mode = m; in_valid = v; out_ready = ordy; cnt_clr = clr;
    step();
  endtask

  initial begin
    rst_n = 1'b0;
    a = '0; b = '0; mode = 2'd0; in_valid = 1'b0; out_ready = 1'b0; cnt_clr = 1'b0;
    cnt_exp = '0;
    #7;
    check_val("rst_out_valid", out_valid, 1'b0);
    check_val("rst_out_data", out_data, 2'd0);
    check_val("rst_out_from_a", out_from_a, 1'b0);
    check_val("rst_count", a_sel_count, 2'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Modes with a=2, b=1, then ties a=b=3
    for (int m = 0; m < 4; m++) drive(2'b10, 2'b01, 2'(m), 1'b1, 1'b1, 1'b0);
    drive(2'd3, 2'd3, 2'd2, 1'b1, 1'b1, 1'b0);
    drive(2'd3, 2'd3, 2'd3, 1'b1, 1'b1, 1'b0);
    drive(2'd0, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0);
    drive(2'd0, 2'd0, 2'd0, 1'b0, 1'b1, 1'b1);

    // Backpressure: hold 1 while a=3 waits, then replace on drain
    drive(2'd1, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drive(2'd3, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0);
    drive(2'd3, 2'd0, 2'd0, 1'b1, 1'b1, 1'b0);
    drive(2'd0, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0);

    // Streaming: back-to-back transactions
    for (int i = 0; i < 4; i++)
      drive(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
            1'b1, 1'b1, 1'b0);
    drive(2'd0, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0);

    // Counter saturation, then clear colliding with an accept
    drive(2'd0, 2'd0, 2'd0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) drive(2'(i), 2'd0, 2'd0, 1'b1, 1'b1, 1'b0);
    drive(2'd1, 2'd0, 2'd0, 1'b1, 1'b1, 1'b1);
    drive(2'd0, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0);

    // Random mix of modes, valid, backpressure and clears
    for (int i = 0; i < 40; i++)
      drive(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0));
    drive(2'd0, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0);
    drive(2'd0, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0);

    // Asynchronous reset while a result is held
    drive(2'd2, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("async_rst_out_valid", out_valid, 1'b0);
    check_val("async_rst_out_data", out_data, 2'd0);
    check_val("async_rst_out_from_a", out_from_a, 1'b0);
    check_val("async_rst_count", a_sel_count, 2'd0);
    exp_q.delete();
    cnt_exp = '0;
    @(negedge clk);
    rst_n = 1'b1;
    drive(2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
